// File: rtl/mmio_bus_pkg.sv
// ---------------------------------------------------------------------------
// mmio_bus_pkg
// Shared definitions for the MMIO peripheral bus: arbiter state encoding,
// chip-select bit positions, address page constants and the default read
// data returned on a timed-out access.
// ---------------------------------------------------------------------------
package mmio_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // One-hot chip-select layout
   localparam int unsigned CS_W   = 5;
   localparam int unsigned CS_RAM = 0;
   localparam int unsigned CS_GFX = 1;
   localparam int unsigned CS_AUD = 2;
   localparam int unsigned CS_SER = 3;
   localparam int unsigned CS_PS2 = 4;

   // Address page (top nibble) of each non-RAM device
   localparam int unsigned PAGE_W   = 4;
   localparam logic [3:0]  PAGE_GFX = 4'hC;
   localparam logic [3:0]  PAGE_AUD = 4'hD;
   localparam logic [3:0]  PAGE_SER = 4'hE;
   localparam logic [3:0]  PAGE_PS2 = 4'hF;

   localparam logic [15:0] DEF_ERR_DATA = 16'hDEAD;

endpackage : mmio_bus_pkg

// File: rtl/mmio_addr_decode.sv
// ---------------------------------------------------------------------------
// mmio_addr_decode
// Combinational address page to one-hot chip-select decode.
// Ports:
//   i_page  in  4         top nibble of the bus address
//   o_cs_c  out CS_W      one-hot select: RAM, graphics, audio, serial, PS/2
// ---------------------------------------------------------------------------
module mmio_addr_decode
   import mmio_bus_pkg::*;
(
   input  logic [PAGE_W-1:0] i_page,
   output logic [CS_W-1:0]   o_cs_c
);

   // Every page outside the device window maps to RAM
   always_comb begin
      o_cs_c = '0;
      unique case (i_page)
         PAGE_GFX: o_cs_c[CS_GFX] = 1'b1;
         PAGE_AUD: o_cs_c[CS_AUD] = 1'b1;
         PAGE_SER: o_cs_c[CS_SER] = 1'b1;
         PAGE_PS2: o_cs_c[CS_PS2] = 1'b1;
         default:  o_cs_c[CS_RAM] = 1'b1;
      endcase
   end

endmodule : mmio_addr_decode

// File: rtl/mmio_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mmio_bus_arbiter
// Two-master round-robin arbiter and access sequencer for the shared MMIO
// peripheral bus. Latches the winning master's request, drives the one-hot
// chip select and strobes, waits for RAM latency or a device ack (with a
// timeout), then returns a one-cycle done pulse and read data to the owner.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   m_req[1:0], m_write[1:0]  per-master request / write flag
//   m0_addr, m1_addr          per-master address
//   m0_wdata, m1_wdata        per-master write data
//   m_done[1:0]               completion pulse to the owning master
//   m_err                     access timed out (valid with m_done)
//   m_rdata                   read data (valid with m_done, held otherwise)
//   cs[4:0]                   one-hot chip select
//   dev_read, dev_write       bus strobes
//   dev_addr, dev_wdata       latched address / write data
//   dev_rdata, dev_ack        device read data / completion
//   stat_m0, stat_m1, stat_tmo  saturating counters (MMIO_BUS_STATS_EN only)
//
// Optional feature: define MMIO_BUS_STATS_EN to add the statistics counters.
// ---------------------------------------------------------------------------
module mmio_bus_arbiter
   import mmio_bus_pkg::*;
#(
   parameter int unsigned       DATA_W   = 16,
   parameter int unsigned       ADDR_W   = 16,
   parameter int unsigned       RAM_WAIT = 1,
   parameter int unsigned       TIMEOUT  = 32,
   parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(DEF_ERR_DATA)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        m_req,
   input  logic [1:0]        m_write,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic [1:0]        m_done,
   output logic              m_err,
   output logic [DATA_W-1:0] m_rdata,
   output logic [CS_W-1:0]   cs,
   output logic              dev_read,
   output logic              dev_write,
   output logic [ADDR_W-1:0] dev_addr,
   output logic [DATA_W-1:0] dev_wdata,
   input  logic [DATA_W-1:0] dev_rdata,
`ifdef MMIO_BUS_STATS_EN
   output logic [DATA_W-1:0] stat_m0,
   output logic [DATA_W-1:0] stat_m1,
   output logic [DATA_W-1:0] stat_tmo,
`endif
   input  logic              dev_ack
);

   localparam int unsigned CNT_W = 8;

   state_t            r_state;
   logic              r_prio;   // master that wins a simultaneous request
   logic              r_owner;
   logic [CNT_W-1:0]  r_cnt;

   logic              w_grant;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;
   logic [CS_W-1:0]   w_cs;
   logic              w_ram_hit;
   logic              w_tmo_hit;
   logic              w_complete;
   logic              w_timeout;
   logic              w_fire;

   // A lone requester wins outright; a tie goes to the priority pointer
   assign w_grant     = (m_req == 2'b11) ? r_prio : m_req[1];
   assign w_sel_addr  = w_grant ? m1_addr  : m0_addr;
   assign w_sel_wdata = w_grant ? m1_wdata : m0_wdata;

   mmio_addr_decode u_decode (
      .i_page (w_sel_addr[ADDR_W-1 -: PAGE_W]),
      .o_cs_c (w_cs)
   );

   // Completion: RAM after a fixed wait, devices on ack or timeout.
   // An ack coinciding with the timeout compare is a success.
   assign w_ram_hit  = (r_cnt == CNT_W'(RAM_WAIT - 1));
   assign w_tmo_hit  = (r_cnt == CNT_W'(TIMEOUT - 1));
   assign w_complete = cs[CS_RAM] ? w_ram_hit : (dev_ack | w_tmo_hit);
   assign w_timeout  = ~cs[CS_RAM] & ~dev_ack & w_tmo_hit;
   assign w_fire     = (r_state == ST_ACCESS) & w_complete;

   // Arbitration / sequencing FSM with registered bus and master outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_prio    <= 1'b0;
         r_owner   <= 1'b0;
         r_cnt     <= '0;
         m_done    <= '0;
         m_err     <= 1'b0;
         m_rdata   <= '0;
         cs        <= '0;
         dev_read  <= 1'b0;
         dev_write <= 1'b0;
         dev_addr  <= '0;
         dev_wdata <= '0;
      end else begin
         m_done <= '0;
         unique case (r_state)
            ST_IDLE: begin
               if (|m_req) begin
                  r_owner   <= w_grant;
                  r_prio    <= ~w_grant;
                  r_cnt     <= '0;
                  cs        <= w_cs;
                  dev_read  <= ~m_write[w_grant];
                  dev_write <= m_write[w_grant];
                  dev_addr  <= w_sel_addr;
                  dev_wdata <= w_sel_wdata;
                  r_state   <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (w_complete) begin
                  cs              <= '0;
                  dev_read        <= 1'b0;
                  dev_write       <= 1'b0;
                  m_done[r_owner] <= 1'b1;
                  m_err           <= w_timeout;
                  // Writes always report zero read data
                  if (dev_write)
                     m_rdata <= '0;
                  else if (w_timeout)
                     m_rdata <= ERR_DATA;
                  else
                     m_rdata <= dev_rdata;
                  r_state <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_DONE: begin
               m_err   <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef MMIO_BUS_STATS_EN
   // Saturating per-master completion and timeout counters
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_m0  <= '0;
         stat_m1  <= '0;
         stat_tmo <= '0;
      end else if (w_fire) begin
         if (!r_owner && stat_m0 != '1)
            stat_m0 <= stat_m0 + DATA_W'(1);
         if (r_owner && stat_m1 != '1)
            stat_m1 <= stat_m1 + DATA_W'(1);
         if (w_timeout && stat_tmo != '1)
            stat_tmo <= stat_tmo + DATA_W'(1);
      end
   end
`endif

endmodule : mmio_bus_arbiter

// File: tb/tb_mmio_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mmio_bus_arbiter
// Directed bench for mmio_bus_arbiter: reset values, RAM and device
// accesses, round-robin arbitration, timeout, ack-at-timeout, mid-access
// reset and (with MMIO_BUS_STATS_EN) the statistics counters.
// ---------------------------------------------------------------------------
module tb_mmio_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  m_req;
   logic [1:0]  m_write;
   logic [15:0] m0_addr, m1_addr;
   logic [15:0] m0_wdata, m1_wdata;
   logic [1:0]  m_done;
   logic        m_err;
   logic [15:0] m_rdata;
   logic [4:0]  cs;
   logic        dev_read, dev_write;
   logic [15:0] dev_addr, dev_wdata, dev_rdata;
   logic        dev_ack;
`ifdef MMIO_BUS_STATS_EN
   logic [15:0] stat_m0, stat_m1, stat_tmo;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mmio_bus_arbiter #(
      .DATA_W   (16),
      .ADDR_W   (16),
      .RAM_WAIT (1),
      .TIMEOUT  (32),
      .ERR_DATA (16'hDEAD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .m_req     (m_req),
      .m_write   (m_write),
      .m0_addr   (m0_addr),
      .m1_addr   (m1_addr),
      .m0_wdata  (m0_wdata),
      .m1_wdata  (m1_wdata),
      .m_done    (m_done),
      .m_err     (m_err),
      .m_rdata   (m_rdata),
      .cs        (cs),
      .dev_read  (dev_read),
      .dev_write (dev_write),
      .dev_addr  (dev_addr),
      .dev_wdata (dev_wdata),
      .dev_rdata (dev_rdata),
`ifdef MMIO_BUS_STATS_EN
      .stat_m0   (stat_m0),
      .stat_m1   (stat_m1),
      .stat_tmo  (stat_tmo),
`endif
      .dev_ack   (dev_ack)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One full transaction from the current negedge; returns the done
   // result, the cs seen in the first ACCESS cycle and the latency in cycles.
   task automatic xfer(input bit m, input logic wr, input logic [15:0] addr,
                       input logic [15:0] wd, input logic [15:0] rd,
                       output logic [1:0] done, output logic err,
                       output logic [15:0] rdat, output logic [4:0] cs0,
                       output int lat);
      if (m) begin m1_addr = addr; m1_wdata = wd; end
      else   begin m0_addr = addr; m0_wdata = wd; end
      m_write[m] = wr;
      m_req[m]   = 1'b1;
      dev_rdata  = rd;
      lat = 0; done = '0; err = 1'b0; rdat = '0; cs0 = '0;
      while (lat < 100) begin
         @(negedge clk);
         lat++;
         if (lat == 1) cs0 = cs;
         if (m_done != 2'b00) begin
            done = m_done; err = m_err; rdat = m_rdata;
            break;
         end
      end
      m_req[m]   = 1'b0;
      m_write[m] = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic [1:0]  x_done;
      logic        x_err;
      logic [15:0] x_rdat;
      logic [4:0]  x_cs;
      int          x_lat;
      int          n_acc;

      rst = 1'b1; m_req = '0; m_write = '0;
      m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
      dev_rdata = '0; dev_ack = 1'b0;
      repeat (3) @(negedge clk);

      // Reset values
      check("rst_cs", 32'(cs), 32'h0);
      check("rst_done", 32'(m_done), 32'h0);
      check("rst_err", 32'(m_err), 32'h0);
      check("rst_rdata", 32'(m_rdata), 32'h0);
      check("rst_strobes", 32'({dev_read, dev_write}), 32'h0);
      check("rst_addr", 32'(dev_addr), 32'h0);
      rst = 1'b0;

      // Ack while idle is ignored
      dev_ack = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_ack_done", 32'(m_done), 32'h0);
      check("idle_ack_cs", 32'(cs), 32'h0);
      dev_ack = 1'b0;

      // M0 RAM read, one ACCESS cycle
      m0_addr = 16'h0100; dev_rdata = 16'h1234; m_req = 2'b01;
      @(negedge clk);
      check("t1_cs", 32'(cs), 32'h01);
      check("t1_read", 32'(dev_read), 32'h1);
      check("t1_addr", 32'(dev_addr), 32'h0100);
      check("t1_not_yet", 32'(m_done), 32'h0);
      @(negedge clk);
      check("t1_done", 32'(m_done), 32'h1);
      check("t1_rdata", 32'(m_rdata), 32'h1234);
      check("t1_err", 32'(m_err), 32'h0);
      check("t1_cs_off", 32'(cs), 32'h0);
      m_req = 2'b00; dev_rdata = 16'h0000;
      @(negedge clk);
      check("t1_pulse", 32'(m_done), 32'h0);
      check("t1_hold", 32'(m_rdata), 32'h1234);

      // M1 audio write, ack on the third ACCESS cycle
      m1_addr = 16'hD002; m1_wdata = 16'hBEEF; m_write = 2'b10; m_req = 2'b10;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         check("t2_cs", 32'(cs), 32'h04);
         check("t2_write", 32'(dev_write), 32'h1);
         check("t2_wdata", 32'(dev_wdata), 32'hBEEF);
         check("t2_not_yet", 32'(m_done), 32'h0);
      end
      dev_ack = 1'b1;
      @(negedge clk);
      check("t2_done", 32'(m_done), 32'h2);
      check("t2_rdata", 32'(m_rdata), 32'h0);
      check("t2_err", 32'(m_err), 32'h0);
      check("t2_write_off", 32'(dev_write), 32'h0);
      dev_ack = 1'b0; m_req = 2'b00; m_write = 2'b00;
      @(negedge clk);

      // Round-robin after a fresh reset
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m0_addr = 16'h0010; m1_addr = 16'h0020; dev_rdata = 16'h1111; m_req = 2'b11;
      @(negedge clk);
      check("rr1_addr", 32'(dev_addr), 32'h0010);
      @(negedge clk);
      check("rr1_done", 32'(m_done), 32'h1);
      check("rr1_rdata", 32'(m_rdata), 32'h1111);
      m_req = 2'b10; dev_rdata = 16'h2222;
      @(negedge clk);
      check("rr_idle_gap", 32'(cs), 32'h0);
      m_req = 2'b11;
      @(negedge clk);
      check("rr2_addr", 32'(dev_addr), 32'h0020);
      @(negedge clk);
      check("rr2_done", 32'(m_done), 32'h2);
      check("rr2_rdata", 32'(m_rdata), 32'h2222);
      m_req = 2'b01;
      @(negedge clk);
      @(negedge clk);
      check("rr3_addr", 32'(dev_addr), 32'h0010);
      @(negedge clk);
      check("rr3_done", 32'(m_done), 32'h1);
      m_req = 2'b00;
      @(negedge clk);

      // PS/2 read with no ack: timeout after 32 ACCESS cycles
      m0_addr = 16'hF000; dev_rdata = 16'h7777; m_req = 2'b01;
      n_acc = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (m_done != 2'b00) break;
         if (cs == 5'b10000) n_acc++;
         if (k == 0) m0_addr = 16'h0000;
      end
      check("tmo_cycles", 32'(n_acc), 32'd32);
      check("tmo_done", 32'(m_done), 32'h1);
      check("tmo_err", 32'(m_err), 32'h1);
      check("tmo_rdata", 32'(m_rdata), 32'hDEAD);
      check("tmo_latched_addr", 32'(dev_addr), 32'hF000);
      m_req = 2'b00;
      @(negedge clk);
      check("tmo_err_clr", 32'(m_err), 32'h0);

      // Graphics read, ack exactly on the timeout compare cycle
      m0_addr = 16'hC000; dev_rdata = 16'h4321; m_req = 2'b01;
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         if (k == 1) check("ackto_cs", 32'(cs), 32'h02);
         if (k == 32) dev_ack = 1'b1;
      end
      @(negedge clk);
      check("ackto_done", 32'(m_done), 32'h1);
      check("ackto_err", 32'(m_err), 32'h0);
      check("ackto_rdata", 32'(m_rdata), 32'h4321);
      dev_ack = 1'b0; m_req = 2'b00;
      @(negedge clk);

      // Serial read, ack in the first ACCESS cycle
      dev_ack = 1'b1;
      xfer(1'b0, 1'b0, 16'hE010, 16'h0, 16'h9999, x_done, x_err, x_rdat, x_cs, x_lat);
      dev_ack = 1'b0;
      check("ser_cs", 32'(x_cs), 32'h08);
      check("ser_lat", 32'(x_lat), 32'd2);
      check("ser_done", 32'(x_done), 32'h1);
      check("ser_rdata", 32'(x_rdat), 32'h9999);

      // Reset during the second ACCESS cycle of a PS/2 read
      m0_addr = 16'hF004; m_req = 2'b01;
      @(negedge clk);
      check("rst_mid_cs_on", 32'(cs), 32'h10);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_cs", 32'(cs), 32'h0);
      check("rst_mid_strobes", 32'({dev_read, dev_write}), 32'h0);
      check("rst_mid_done", 32'(m_done), 32'h0);
      rst = 1'b0; m_req = 2'b00;
      @(negedge clk);
      check("rst_mid_no_done", 32'(m_done), 32'h0);
      xfer(1'b0, 1'b0, 16'h0200, 16'h0, 16'h5A5A, x_done, x_err, x_rdat, x_cs, x_lat);
      check("post_rst_lat", 32'(x_lat), 32'd2);
      check("post_rst_done", 32'(x_done), 32'h1);
      check("post_rst_rdata", 32'(x_rdat), 32'h5A5A);
      check("post_rst_err", 32'(x_err), 32'h0);

`ifdef MMIO_BUS_STATS_EN
      // Statistics: three M0 transactions and one M1 timeout
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("stat_rst_m0", 32'(stat_m0), 32'h0);
      for (int i = 0; i < 3; i++)
         xfer(1'b0, 1'b1, 16'h0300, 16'h00AA, 16'h0, x_done, x_err, x_rdat, x_cs, x_lat);
      xfer(1'b1, 1'b0, 16'hE000, 16'h0, 16'h0, x_done, x_err, x_rdat, x_cs, x_lat);
      check("stat_tmo_err", 32'(x_err), 32'h1);
      check("stat_m0", 32'(stat_m0), 32'd3);
      check("stat_m1", 32'(stat_m1), 32'd1);
      check("stat_tmo", 32'(stat_tmo), 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_mmio_bus_arbiter
